// File: rtl/cck_edge_gen.sv
// CCK edge generator: synchronises and filters the CCK pin, measures its period,
// locks a local phase counter to it and derives CCK/CCKQ/CDAC strobes.
module cck_edge_gen #(
  parameter int RATIO  = 16,
  parameter int FILT   = 2,
  parameter int TOL    = 1,
  parameter int LOCK_N = 4,
  parameter int MISS_N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cck_in,
  output logic                     cck,
  output logic                     cckq,
  output logic                     cck_edge,
  output logic                     cckq_edge,
  output logic                     cdac_edge,
  output logic [$clog2(RATIO)-1:0] phase,
  output logic [7:0]               period,
  output logic                     locked
);
  localparam int PW = $clog2(RATIO);
  localparam int Q  = RATIO / 8;

  localparam logic [PW-1:0] PH_LAST = PW'(RATIO - 1);
  localparam logic [PW-1:0] PH_Q1   = PW'(Q);
  localparam logic [PW-1:0] PH_Q2   = PW'(2 * Q);
  localparam logic [PW-1:0] PH_Q3   = PW'(3 * Q);
  localparam logic [PW-1:0] PH_Q4   = PW'(4 * Q);
  localparam logic [PW-1:0] PH_Q5   = PW'(5 * Q);
  localparam logic [PW-1:0] PH_Q6   = PW'(6 * Q);
  localparam logic [PW-1:0] PH_Q7   = PW'(7 * Q);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  logic          sync1_q, sync2_q;
  logic          cck_q, cck_d, cck_prev_q;
  logic [2:0]    filt_cnt_q, filt_cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    period_q, period_d;
  logic [7:0]    good_q, good_d;
  logic [7:0]    miss_q, miss_d;
  state_t        state_q, state_d;
  logic          locked_q;

  logic          rise, wrap, flywheel, good_period;
  logic [8:0]    dev;

  // Level filter: flip only after FILT consecutive synced samples disagree.
  always_comb begin
    cck_d      = cck_q;
    filt_cnt_d = '0;
    if (sync2_q != cck_q) begin
      if (filt_cnt_q == 3'(FILT - 1)) begin
        cck_d = ~cck_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 3'd1;
      end
    end
  end

  assign rise        = cck_q & ~cck_prev_q;
  assign wrap        = (phase_q == PH_LAST);
  assign flywheel    = wrap & ~rise;
  assign dev         = (cnt_q >= 8'(RATIO)) ? ({1'b0, cnt_q} - 9'(RATIO))
                                            : (9'(RATIO) - {1'b0, cnt_q});
  assign good_period = (dev <= 9'(TOL));

  // A flywheel wrap restarts the period count so a single dropped rise
  // does not make the following real rise look twice as late.
  always_comb begin
    phase_d  = (rise || wrap) ? '0 : phase_q + PW'(1);
    cnt_d    = (cnt_q == 8'd255) ? cnt_q : cnt_q + 8'd1;
    if (rise || ((state_q == LOCKED) && flywheel)) begin
      cnt_d = 8'd1;
    end
    period_d = rise ? cnt_q : period_q;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    case (state_q)
      UNLOCKED: begin
        if (rise) begin
          state_d = ACQUIRE;
          good_d  = '0;
          miss_d  = '0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          if (good_period) begin
            good_d = good_q + 8'd1;
            if (good_d >= 8'(LOCK_N)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            good_d = '0;
          end
        end else if (cnt_q >= 8'(2 * RATIO)) begin
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (rise) begin
          miss_d = good_period ? 8'd0 : miss_q + 8'd1;
        end else if (flywheel) begin
          miss_d = miss_q + 8'd1;
        end
        if (miss_d >= 8'(MISS_N)) begin
          state_d = UNLOCKED;
          miss_d  = '0;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cck_q      <= 1'b0;
      cck_prev_q <= 1'b0;
      filt_cnt_q <= '0;
      phase_q    <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      good_q     <= '0;
      miss_q     <= '0;
      state_q    <= UNLOCKED;
      locked_q   <= 1'b0;
    end else begin
      sync1_q    <= cck_in;
      sync2_q    <= sync1_q;
      cck_q      <= cck_d;
      cck_prev_q <= cck_q;
      filt_cnt_q <= filt_cnt_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      state_q    <= state_d;
      locked_q   <= (state_d == LOCKED);
    end
  end

  // Locked: strobes come from the flywheel phase; otherwise only raw CCK edges.
  always_comb begin
    cck_edge  = 1'b0;
    cckq_edge = 1'b0;
    cdac_edge = 1'b0;
    cckq      = 1'b0;
    if (locked_q) begin
      cck_edge  = (phase_q == '0) || (phase_q == PH_Q4);
      cckq_edge = (phase_q == PH_Q2) || (phase_q == PH_Q6);
      cdac_edge = (phase_q == PH_Q1) || (phase_q == PH_Q3) ||
                  (phase_q == PH_Q5) || (phase_q == PH_Q7);
      cckq      = (phase_q >= PH_Q2) && (phase_q < PH_Q6);
    end else begin
      cck_edge  = cck_q ^ cck_prev_q;
    end
  end

  assign cck    = cck_q;
  assign phase  = phase_q;
  assign period = period_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_cck_edge_gen.sv
// Bench for cck_edge_gen: table of waveform scenarios, hand-written corner
// sequences and randomized periods, all compared cycle by cycle with a timestamp model.
module tb_cck_edge_gen;
  localparam int R      = 16;
  localparam int FILT   = 2;
  localparam int TOL    = 1;
  localparam int LOCK_N = 4;
  localparam int MISS_N = 2;
  localparam int Q      = R / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cck_in = 1'b0;
  logic       cck, cckq, cck_edge, cckq_edge, cdac_edge, locked;
  logic [3:0] phase;
  logic [7:0] period;

  cck_edge_gen #(.RATIO(R), .FILT(FILT), .TOL(TOL), .LOCK_N(LOCK_N), .MISS_N(MISS_N)) dut (
    .clk(clk), .rst_n(rst_n), .cck_in(cck_in), .cck(cck), .cckq(cckq),
    .cck_edge(cck_edge), .cckq_edge(cckq_edge), .cdac_edge(cdac_edge),
    .phase(phase), .period(period), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: events kept as cycle timestamps; phase is derived from the last rise time.
  int m_cyc, m_last_rise, m_ref, m_period, m_state, m_good, m_miss, m_run, m_rises;
  bit m_cck, m_cck_prev;
  bit m_dly[$];

  int acc_ce, acc_qd, acc_cck, mask_ce, mask_qe, mask_de, mask_q, wpos;
  bit acc_locked_any, acc_unlocked_any;

  typedef struct {
    int hi; int len; int nper; int exp_period; bit exp_locked; bit exp_qd;
  } vec_t;
  vec_t tbl[7];

  function automatic int pack(bit c, bit cq, bit ce, bit qe, bit de, bit lk, int ph, int per);
    return per | (ph << 8) | (int'(lk) << 16) | (int'(de) << 17) | (int'(qe) << 18) |
           (int'(ce) << 19) | (int'(cq) << 20) | (int'(c) << 21);
  endfunction

  function automatic int dut_vec();
    return pack(cck, cckq, cck_edge, cckq_edge, cdac_edge, locked, int'(phase), int'(period));
  endfunction

  function automatic int m_phase();
    return (((m_cyc - m_last_rise - 1) % R) + R) % R;
  endfunction

  function automatic int m_count();
    int c = m_cyc - m_ref;
    return (c > 255) ? 255 : c;
  endfunction

  function automatic int m_expect();
    int ph = m_phase();
    bit lk = (m_state == 2);
    bit ce, qe, de, q;
    if (lk) begin
      ce = (ph == 0) || (ph == 4 * Q);
      qe = (ph == 2 * Q) || (ph == 6 * Q);
      de = (ph % (2 * Q)) == Q;
      q  = (ph >= 2 * Q) && (ph < 6 * Q);
    end else begin
      ce = (m_cck != m_cck_prev);
      qe = 1'b0; de = 1'b0; q = 1'b0;
    end
    return pack(m_cck, q, ce, qe, de, lk, ph, m_period);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_last_rise = -1; m_ref = 0; m_period = 0; m_state = 0;
    m_good = 0; m_miss = 0; m_run = 0; m_rises = 0; m_cck = 0; m_cck_prev = 0;
    m_dly.delete(); m_dly.push_back(1'b0); m_dly.push_back(1'b0);
  endtask

  task automatic model_edge(input bit v);
    bit rise = m_cck && !m_cck_prev;
    int ph = m_phase();
    int cnt = m_count();
    bit wrap = (ph == R - 1) && !rise;
    int dev = (cnt > R) ? cnt - R : R - cnt;
    bit good = (dev <= TOL);
    int prev_state = m_state;
    bit s;
    case (m_state)
      0: if (rise) begin m_state = 1; m_good = 0; end
      1: begin
        if (rise) begin
          if (good) begin
            m_good++;
            if (m_good >= LOCK_N) begin m_state = 2; m_miss = 0; end
          end else m_good = 0;
        end else if (cnt >= 2 * R) m_state = 0;
      end
      default: begin
        if (rise) m_miss = good ? 0 : m_miss + 1;
        else if (wrap) m_miss++;
        if (m_miss >= MISS_N) begin m_state = 0; m_miss = 0; end
      end
    endcase
    if (rise) begin
      m_ref = m_cyc; m_last_rise = m_cyc; m_period = cnt; m_rises++;
    end else if (prev_state == 2 && wrap) begin
      m_ref = m_cyc;
    end
    s = m_dly.pop_front();
    m_dly.push_back(v);
    m_cck_prev = m_cck;
    if (s != m_cck) begin
      m_run++;
      if (m_run >= FILT) begin m_cck = !m_cck; m_run = 0; end
    end else m_run = 0;
    m_cyc++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic clear_acc();
    acc_ce = 0; acc_qd = 0; acc_cck = 0; mask_ce = 0; mask_qe = 0; mask_de = 0; mask_q = 0;
    acc_locked_any = 0; acc_unlocked_any = 0;
  endtask

  task automatic step(input bit v);
    int ph;
    cck_in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    chk($sformatf("cycle%0d", m_cyc), dut_vec(), m_expect());
    ph = m_phase();
    acc_ce  += int'(cck_edge);
    acc_qd  += int'(cckq_edge) + int'(cdac_edge);
    acc_cck += int'(cck);
    if (cck_edge)  mask_ce |= (1 << ph);
    if (cckq_edge) mask_qe |= (1 << ph);
    if (cdac_edge) mask_de |= (1 << ph);
    if (cckq)      mask_q  |= (1 << ph);
    if (locked) acc_locked_any = 1; else acc_unlocked_any = 1;
  endtask

  task automatic wave(input int hi, input int len);
    step((wpos % len) < hi);
    wpos++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", dut_vec(), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    wpos = 0;
    clear_acc();
  endtask

  task automatic run_to_rises(input int n);
    int guard = 0;
    while (m_rises < n && guard < 400) begin
      wave(8, 16);
      guard++;
    end
    chk("rise_bound", m_rises, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{hi: 8, len: 16, nper: 8,  exp_period: 16, exp_locked: 1, exp_qd: 1};
    tbl[1] = '{hi: 9, len: 18, nper: 10, exp_period: 18, exp_locked: 0, exp_qd: 0};
    tbl[2] = '{hi: 8, len: 17, nper: 9,  exp_period: 17, exp_locked: 1, exp_qd: 1};
    tbl[3] = '{hi: 7, len: 15, nper: 9,  exp_period: 15, exp_locked: 1, exp_qd: 1};
    tbl[4] = '{hi: 7, len: 14, nper: 10, exp_period: 14, exp_locked: 0, exp_qd: 0};
    tbl[5] = '{hi: 4, len: 8,  nper: 12, exp_period: 8,  exp_locked: 0, exp_qd: 0};
    tbl[6] = '{hi: 12, len: 24, nper: 8, exp_period: 24, exp_locked: 0, exp_qd: 0};

    model_reset();
    #1 chk("reset_state", dut_vec(), 0);

    foreach (tbl[i]) begin
      do_reset();
      repeat (tbl[i].nper * tbl[i].len) wave(tbl[i].hi, tbl[i].len);
      chk("tbl_period", int'(period), tbl[i].exp_period);
      chk("tbl_locked_seen", int'(acc_locked_any), int'(tbl[i].exp_locked));
      chk("tbl_qd_seen", int'(acc_qd > 0), int'(tbl[i].exp_qd));
      $display("row %0d: hi=%0d len=%0d period=%0d locked_seen=%0d", i, tbl[i].hi,
               tbl[i].len, period, acc_locked_any);
    end

    // Clean lock: lock on the 5th rise, then strobe map over one full period.
    do_reset();
    run_to_rises(4);
    chk("lock_after_4", int'(locked), 0);
    run_to_rises(5);
    chk("lock_after_5", int'(locked), 1);
    chk("clean_period", int'(period), 16);
    for (int g = 0; g < 20 && m_phase() != R - 1; g++) wave(8, 16);
    clear_acc();
    repeat (R) wave(8, 16);
    chk("mask_cck_edge", mask_ce, 'h0101);
    chk("mask_cckq_edge", mask_qe, 'h1010);
    chk("mask_cdac_edge", mask_de, 'h4444);
    chk("mask_cckq", mask_q, 'h0FF0);
    $display("seq clean_lock: period=%0d locked=%0d", period, locked);

    // Glitch in the low half while acquiring.
    do_reset();
    repeat (3 * 16) wave(8, 16);
    for (int k = 0; k < 12; k++) step(k < 8);
    clear_acc();
    for (int k = 12; k < 16; k++) step(k == 12);
    for (int k = 0; k < 3; k++) step(1'b1);
    chk("glitch_no_edge", acc_ce, 0);
    chk("glitch_cck_low", acc_cck, 0);
    chk("glitch_period", int'(period), 16);
    for (int k = 3; k < 16; k++) step(k < 8);
    chk("glitch_period_next", int'(period), 16);
    $display("seq glitch: period=%0d", period);

    // Flywheel: one dropped rise keeps lock, two consecutive drop it.
    do_reset();
    repeat (7 * 16) wave(8, 16);
    clear_acc();
    repeat (16) step(1'b0);
    chk("fly1_edges", acc_ce, 2);
    chk("fly1_mask", mask_ce, 'h0101);
    chk("fly1_stayed_locked", int'(acc_unlocked_any), 0);
    wpos = 0;
    repeat (2 * 16) wave(8, 16);
    repeat (16) step(1'b0);
    chk("fly2_after_first", int'(locked), 1);
    repeat (16) step(1'b0);
    chk("fly2_after_second", int'(locked), 0);
    $display("seq flywheel: locked=%0d", locked);

    // Realignment: a 10-cycle period while locked, then a dropped rise unlocks.
    do_reset();
    repeat (7 * 16) wave(8, 16);
    for (int k = 0; k < 10; k++) step(k < 5);
    for (int k = 0; k < 5; k++) step(1'b1);
    chk("realign_phase", int'(phase), 0);
    chk("realign_period", int'(period), 10);
    chk("realign_locked", int'(locked), 1);
    for (int k = 5; k < 16; k++) step(k < 8);
    repeat (16) step(1'b0);
    chk("realign_miss_then_drop", int'(locked), 0);
    $display("seq realign: period=%0d locked=%0d", period, locked);

    // Reset while locked: immediate clear, then full reacquisition.
    do_reset();
    repeat (8 * 16) wave(8, 16);
    chk("pre_reset_locked", int'(locked), 1);
    #3 rst_n = 1'b0;
    #1 chk("midlock_reset_outputs", dut_vec(), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    wpos = 0;
    run_to_rises(4);
    chk("relock_after_4", int'(locked), 0);
    run_to_rises(5);
    chk("relock_after_5", int'(locked), 1);
    $display("seq reset_midlock: locked=%0d", locked);

    // Randomized periods, drops and glitches.
    do_reset();
    repeat (6 * 16) wave(8, 16);
    for (int p = 0; p < 80; p++) begin
      int len = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(13, 19));
      int hi = len / 2;
      bit drop = ($urandom_range(0, 9) == 0);
      int gl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(hi + 1, len - 2)) : -1;
      for (int k = 0; k < len; k++) step(!drop && ((k < hi) || (k == gl)));
    end
    $display("seq random: cycles=%0d period=%0d locked=%0d", m_cyc, period, locked);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cck_edge_gen.md
CCK_EDGE_GEN -- requirements
Module: cck_edge_gen

Interface
REQ-001 SHALL have parameter RATIO, default 16, giving nominal clk cycles per CCK period; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter FILT, default 2, giving consecutive identical samples needed to accept a CCK level change; legal range 1..4.
REQ-003 SHALL have parameter TOL, default 1, giving the allowed deviation of a measured period from RATIO, in clk cycles.
REQ-004 SHALL have parameter LOCK_N, default 4, giving consecutive good periods required to lock.
REQ-005 SHALL have parameter MISS_N, default 2, giving consecutive missed or bad periods that force unlock.
REQ-006 SHALL have port: clk  in  1  56 MHz system clock; the only clock.
REQ-007 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port: cck_in  in  1  raw CCK pin, asynchronous to clk.
REQ-009 SHALL have port: cck  out  1  filtered CCK level.
REQ-010 SHALL have port: cckq  out  1  quadrature CCK level, valid while locked.
REQ-011 SHALL have port: cck_edge, cckq_edge, cdac_edge  out  1 each  single-cycle strobes.
REQ-012 SHALL have port: phase  out  clog2(RATIO)  position within the CCK period.
REQ-013 SHALL have port: period  out  8  last measured CCK period in clk cycles.
REQ-014 SHALL have port: locked  out  1  lock status.

Function
REQ-015 SHALL pass cck_in through a 2-flop synchroniser, then through a filter that toggles cck only after FILT consecutive synced samples differ from the current cck level; total input-to-cck latency is 2+FILT cycles.
REQ-016 SHALL define a rise as the cycle in which cck goes 0->1.
REQ-017 SHALL show phase=0 in the cycle after a rise, increment phase each cycle, and wrap from RATIO-1 to 0.
REQ-018 SHALL count clk cycles between successive rises, saturating at 255, and load that count into period on each rise.
REQ-019 SHALL classify a period as good when |count-RATIO| <= TOL, and otherwise as bad.
REQ-020 SHALL implement a lock FSM with states UNLOCKED, ACQUIRE and LOCKED, transitioning as follows:
- UNLOCKED -> ACQUIRE on any rise, with good count cleared.
- ACQUIRE: a good rise increments good count; a bad rise clears good count and stays in ACQUIRE.
- ACQUIRE -> LOCKED when good count reaches LOCK_N.
- ACQUIRE -> UNLOCKED when no rise occurs within 2*RATIO cycles.
- LOCKED: a good rise clears the miss count.
- LOCKED: a bad rise increments the miss count and realigns phase to 0.
- LOCKED: a phase wrap without a rise in the same cycle (flywheel) increments the miss count.
- LOCKED -> UNLOCKED when the miss count reaches MISS_N.
REQ-021 SHALL drive locked=1 exactly while the FSM is in LOCKED, registered.
REQ-022 SHALL, while LOCKED, derive strobes from phase with Q=RATIO/8:
- cck_edge at phase 0 and 4Q.
- cckq_edge at phase 2Q and 6Q.
- cdac_edge at phase Q, 3Q, 5Q and 7Q.
REQ-023 SHALL, while LOCKED, drive cckq=1 for phase in [2Q, 6Q) and 0 otherwise.
REQ-024 SHALL, outside LOCKED, pulse cck_edge for one cycle on every cck transition and hold cckq, cckq_edge and cdac_edge at 0.
REQ-025 SHALL NOT fire catch-up strobes for phase values skipped by a realignment, and SHALL NOT fire a double strobe when a rise coincides with a flywheel wrap; that coincident case counts as a rise, not a miss.

Reset
REQ-026 SHALL, on rst_n=0, immediately clear all outputs, the synchroniser, the filter, all counters and the FSM (to UNLOCKED) to 0.
REQ-027 SHALL resume operation on the first clk edge after rst_n deasserts, requiring full reacquisition.

Verification
REQ-028 SHALL verify clean lock: cck_in with 8 cycles high and 8 low (defaults) -> period=16; locked=1 after the 5th rise; per period, cck_edge at phases 0 and 8, cckq_edge at 4 and 12, cdac_edge at 2, 6, 10 and 14; cckq high at phases 4..11.
REQ-029 SHALL verify glitch rejection: a 1-cycle high pulse on cck_in during the low half -> cck unchanged, no strobes, period unchanged.
REQ-030 SHALL verify flywheel: while locked, drop one rise -> synthetic cck_edge at phase 0 and locked stays 1; drop two consecutive rises -> locked=0 after the second wrap.
REQ-031 SHALL verify out-of-tolerance input: an 18-cycle period -> period=18, locked never asserts, cckq_edge and cdac_edge stay 0.
REQ-032 SHALL verify realignment: while locked, a rise arriving at phase 10 -> phase=0 next cycle, period=10, miss count 1, locked still 1.
REQ-033 SHALL verify reset mid-lock: rst_n pulsed low -> all outputs 0 with no clk edge; after release, locked reasserts after the 5th rise.
